// File: rtl/ddrc_status_read.sv
// Read-side status window of the DDRC register block: live sequencer/MMCM status,
// run-done counter and sticky flags, plus a coherent shadow snapshot bank.
module ddrc_status_read #(
    parameter int unsigned                   AXI_RD_ADDR_BITS = 12,
    parameter logic [AXI_RD_ADDR_BITS-1:0]   SELECT_ADDR      = 12'h800,
    parameter logic [AXI_RD_ADDR_BITS-1:0]   SELECT_ADDR_MASK = 12'h800,
    parameter logic [AXI_RD_ADDR_BITS-1:0]   BUSY_ADDR        = 12'hc00,
    parameter logic [AXI_RD_ADDR_BITS-1:0]   BUSY_ADDR_MASK   = 12'hc00
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AXI_RD_ADDR_BITS-1:0] pre_raddr,
    input  logic                        start_rburst,
    input  logic [AXI_RD_ADDR_BITS-1:0] raddr,
    input  logic                        rd_en,
    output logic [31:0]                 rdata,
    output logic                        rdata_valid,
    output logic                        busy,
    input  logic                        run_done,
    input  logic                        seq_busy,
    input  logic                        dly_ready,
    input  logic [3:0]                  locked,
    input  logic [7:0]                  ps_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNAP1 = 2'd1,
        SNAP2 = 2'd2
    } state_t;

    function automatic logic addr_match(
        input logic [AXI_RD_ADDR_BITS-1:0] addr,
        input logic [AXI_RD_ADDR_BITS-1:0] val,
        input logic [AXI_RD_ADDR_BITS-1:0] mask
    );
        return ((addr ^ val) & mask) == {AXI_RD_ADDR_BITS{1'b0}};
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] run_cnt_r;
    logic        done_seen_r;
    logic        lock_lost_r;
    logic [3:0]  locked_d_r;
    logic [15:0] shadow_cnt_r;
    logic [1:0]  shadow_sticky_r;
    logic        s1_valid_r;
    logic [31:0] s1_data_r;
    logic [31:0] rdata_r;
    logic        rdata_valid_r;

    logic        sel_s;
    logic        shd_s;
    logic        pre_shd_s;
    logic        rd_hit_s;
    logic        clr_s;
    logic        fall_s;
    logic [31:0] src_data_s;

    assign sel_s     = addr_match(raddr, SELECT_ADDR, SELECT_ADDR_MASK);
    assign shd_s     = addr_match(raddr, BUSY_ADDR, BUSY_ADDR_MASK);
    assign pre_shd_s = addr_match(pre_raddr, BUSY_ADDR, BUSY_ADDR_MASK);
    assign rd_hit_s  = rd_en & sel_s;
    // Only a live read of the sticky register clears it; shadow reads are side-effect free.
    assign clr_s     = rd_hit_s & (raddr[1:0] == 2'd2) & ~shd_s;
    assign fall_s    = |(locked_d_r & ~locked);

    assign busy        = (start_rburst & pre_shd_s) | (state_r != IDLE);
    assign rdata       = rdata_r;
    assign rdata_valid = rdata_valid_r;

    // Source select for the addressed register, sampled by pipeline stage 1.
    always_comb begin
        src_data_s = 32'h0000_0000;
        case (raddr[1:0])
            2'd0:    src_data_s = {26'd0, locked, dly_ready, seq_busy};
            2'd1:    src_data_s = shd_s ? {16'd0, shadow_cnt_r} : {16'd0, run_cnt_r};
            2'd2:    src_data_s = shd_s ? {30'd0, shadow_sticky_r} : {30'd0, lock_lost_r, done_seen_r};
            2'd3:    src_data_s = {24'd0, ps_out};
            default: src_data_s = 32'h0000_0000;
        endcase
    end

    // Snapshot sequencer next state; requests outside IDLE are ignored.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_rburst && pre_shd_s) begin
                    state_nxt_s = SNAP1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SNAP1:   state_nxt_s = SNAP2;
            SNAP2:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, counters, sticky flags, shadow bank and the two-stage read pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            run_cnt_r       <= 16'd0;
            done_seen_r     <= 1'b0;
            lock_lost_r     <= 1'b0;
            locked_d_r      <= 4'd0;
            shadow_cnt_r    <= 16'd0;
            shadow_sticky_r <= 2'd0;
            s1_valid_r      <= 1'b0;
            s1_data_r       <= 32'h0000_0000;
            rdata_r         <= 32'h0000_0000;
            rdata_valid_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            run_cnt_r   <= run_cnt_r + {15'd0, run_done};
            locked_d_r  <= locked;
            // Set events take priority over a coincident clear.
            done_seen_r <= (done_seen_r & ~clr_s) | run_done;
            lock_lost_r <= (lock_lost_r & ~clr_s) | fall_s;
            if (state_r == SNAP1) begin
                shadow_cnt_r    <= run_cnt_r;
                shadow_sticky_r <= {lock_lost_r, done_seen_r};
            end else begin
                shadow_cnt_r    <= shadow_cnt_r;
                shadow_sticky_r <= shadow_sticky_r;
            end
            s1_valid_r    <= rd_hit_s;
            s1_data_r     <= rd_hit_s ? src_data_s : 32'h0000_0000;
            rdata_valid_r <= s1_valid_r;
            rdata_r       <= s1_valid_r ? s1_data_r : 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_ddrc_status_read.sv
// Directed self-checking bench for ddrc_status_read.
module tb_ddrc_status_read;

    logic        clk;
    logic        rst;
    logic [11:0] pre_raddr;
    logic        start_rburst;
    logic [11:0] raddr;
    logic        rd_en;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        busy;
    logic        run_done;
    logic        seq_busy;
    logic        dly_ready;
    logic [3:0]  locked;
    logic [7:0]  ps_out;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    ddrc_status_read dut (
        .clk          (clk),
        .rst          (rst),
        .pre_raddr    (pre_raddr),
        .start_rburst (start_rburst),
        .raddr        (raddr),
        .rd_en        (rd_en),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .busy         (busy),
        .run_done     (run_done),
        .seq_busy     (seq_busy),
        .dly_ready    (dly_ready),
        .locked       (locked),
        .ps_out       (ps_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle read; returns valid seen at N+1 and data/valid seen at N+2.
    task automatic issue_read(input logic [11:0] addr, output logic v1,
                              output logic [31:0] d2, output logic v2);
        raddr = addr;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        v1 = rdata_valid;
        step();
        d2 = rdata;
        v2 = rdata_valid;
    endtask

    task automatic pulse_run_done(input int n);
        for (int i = 0; i < n; i++) begin
            run_done = 1'b1;
            step();
        end
        run_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_en = 1'b1; raddr = 12'h801;
        step();
        step();
        rst = 1'b0; rd_en = 1'b0;
        chk_cnt++;
        if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0);
        else pass_cnt++;
        chk_cnt++;
        if (rdata_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rdata_valid);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_cnt++;
            if (rdata_valid !== 1'b0) $display("FAIL reset_late_valid: cycle %0d got %b want 0", i, rdata_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_run_cnt();
        logic v1, v2;
        logic [31:0] d2;
        pulse_run_done(3);
        issue_read(12'h801, v1, d2, v2);
        chk_cnt++;
        if (v1 !== 1'b0) $display("FAIL runcnt_early_valid: got %b want 0", v1);
        else pass_cnt++;
        chk_cnt++;
        if (d2 !== 32'h3) $display("FAIL runcnt_data: got %h want %h", d2, 32'h3);
        else pass_cnt++;
        chk_cnt++;
        if (v2 !== 1'b1) $display("FAIL runcnt_valid: got %b want 1", v2);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (rdata_valid !== 1'b0 || rdata !== 32'h0)
            $display("FAIL runcnt_pulse: got valid %b data %h want 0/0", rdata_valid, rdata);
        else pass_cnt++;
    endtask

    task automatic test_sticky();
        logic v1, v2;
        logic [31:0] d2;
        pulse_run_done(1);
        issue_read(12'h802, v1, d2, v2);
        chk_cnt++;
        if (d2 !== 32'h1 || v2 !== 1'b1) $display("FAIL sticky_first: got %h/%b want 1/1", d2, v2);
        else pass_cnt++;
        issue_read(12'h802, v1, d2, v2);
        chk_cnt++;
        if (d2 !== 32'h0 || v2 !== 1'b1) $display("FAIL sticky_cleared: got %h/%b want 0/1", d2, v2);
        else pass_cnt++;
        raddr = 12'h802; rd_en = 1'b1; run_done = 1'b1;
        step();
        rd_en = 1'b0; run_done = 1'b0;
        step();
        chk_cnt++;
        if (rdata !== 32'h0 || rdata_valid !== 1'b1)
            $display("FAIL sticky_coincident_read: got %h/%b want 0/1", rdata, rdata_valid);
        else pass_cnt++;
        issue_read(12'h802, v1, d2, v2);
        chk_cnt++;
        if (d2 !== 32'h1) $display("FAIL sticky_set_wins: got %h want %h", d2, 32'h1);
        else pass_cnt++;
    endtask

    // run_cnt is 5 here: 3 from test_run_cnt plus 2 from test_sticky.
    task automatic test_snapshot();
        logic v1, v2;
        logic [31:0] d2;
        pre_raddr = 12'hc00; start_rburst = 1'b1;
        #1;
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL busy_comb: got %b want 1", busy);
        else pass_cnt++;
        step();
        start_rburst = 1'b0;
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL busy_snap1: got %b want 1", busy);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL busy_snap2: got %b want 1", busy);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL busy_idle: got %b want 0", busy);
        else pass_cnt++;
        pulse_run_done(5);
        issue_read(12'hc01, v1, d2, v2);
        chk_cnt++;
        if (d2 !== 32'h5 || v2 !== 1'b1) $display("FAIL shadow_cnt: got %h/%b want 5/1", d2, v2);
        else pass_cnt++;
        issue_read(12'h801, v1, d2, v2);
        chk_cnt++;
        if (d2 !== 32'ha) $display("FAIL live_cnt_after_snap: got %h want %h", d2, 32'ha);
        else pass_cnt++;
        issue_read(12'hc02, v1, d2, v2);
        chk_cnt++;
        if (d2 !== 32'h0) $display("FAIL shadow_sticky: got %h want %h", d2, 32'h0);
        else pass_cnt++;
        issue_read(12'h802, v1, d2, v2);
        chk_cnt++;
        if (d2 !== 32'h1) $display("FAIL live_sticky_not_cleared_by_shadow: got %h want %h", d2, 32'h1);
        else pass_cnt++;
    endtask

    task automatic test_wrap_and_lock();
        logic v1, v2;
        logic [31:0] d2;
        rst = 1'b1;
        step();
        rst = 1'b0;
        pulse_run_done(65536);
        issue_read(12'h801, v1, d2, v2);
        chk_cnt++;
        if (d2 !== 32'h0 || v2 !== 1'b1) $display("FAIL runcnt_wrap: got %h/%b want 0/1", d2, v2);
        else pass_cnt++;
        locked = 4'hf;
        step();
        locked = 4'hd;
        step();
        issue_read(12'h802, v1, d2, v2);
        chk_cnt++;
        if (d2 !== 32'h3) $display("FAIL lock_lost: got %h want %h", d2, 32'h3);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        dly_ready = 1'b1; seq_busy = 1'b0; ps_out = 8'h5a;
        raddr = 12'h800; rd_en = 1'b1;
        step();
        raddr = 12'h001;
        step();
        chk_cnt++;
        if (rdata_valid !== 1'b1 || rdata !== 32'h36)
            $display("FAIL b2b_status: got %h/%b want 36/1", rdata, rdata_valid);
        else pass_cnt++;
        raddr = 12'h803;
        step();
        rd_en = 1'b0;
        chk_cnt++;
        if (rdata_valid !== 1'b0 || rdata !== 32'h0)
            $display("FAIL b2b_gap: got %h/%b want 0/0", rdata, rdata_valid);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (rdata_valid !== 1'b1 || rdata !== 32'h5a)
            $display("FAIL b2b_phase: got %h/%b want 5a/1", rdata, rdata_valid);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (rdata_valid !== 1'b0) $display("FAIL b2b_tail: got %b want 0", rdata_valid);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; pre_raddr = 12'h0; start_rburst = 1'b0; raddr = 12'h0; rd_en = 1'b0;
        run_done = 1'b0; seq_busy = 1'b0; dly_ready = 1'b0; locked = 4'h0; ps_out = 8'h0;
        test_reset();
        test_run_cnt();
        test_sticky();
        test_snapshot();
        test_wrap_and_lock();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
